// File: rtl/uart_core.sv
// Full-duplex UART: valid/ready transmitter and mid-bit-sampling receiver on one clock.
// Optional parity bit is enabled by defining UART_PARITY_EN.
module uart_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
    // tx_ready stays low for the whole frame and tx_valid is ignored meanwhile.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

`ifdef UART_PARITY_EN
    localparam logic ODD = PARITY_ODD[0];
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
`endif

    // ---------------- transmitter ----------------
    state_t                 tx_state;
    logic [CNT_W-1:0]       tx_cnt;
    logic [IDX_W-1:0]       tx_idx;
    logic [DATA_BITS-1:0]   tx_shift;
`ifdef UART_PARITY_EN
    logic                   tx_par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_o     <= 1'b1;
            tx_ready <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        tx_state <= ST_START;
                        tx_o     <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_cnt   <= '0;
                        tx_shift <= tx_data;
`ifdef UART_PARITY_EN
                        tx_par   <= (^tx_data) ^ ODD;
`endif
                    end
                end
                ST_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state <= ST_DATA;
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_o     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state <= ST_PARITY;
                            tx_o     <= tx_par;
`else
                            tx_state <= ST_STOP;
                            tx_o     <= 1'b1;
                            tx_idx   <= '0;
`endif
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_o     <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state <= ST_STOP;
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_o     <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // tx_idx counts stop bits here so the bit counter never wraps mid-bit
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == STOP_LAST) begin
                            tx_state <= ST_IDLE;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= ST_IDLE;
                    tx_o     <= 1'b1;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    state_t                 rx_state;
    logic [CNT_W-1:0]       rx_cnt;
    logic [IDX_W-1:0]       rx_idx;
    logic [DATA_BITS-1:0]   rx_shift;
`ifdef UART_PARITY_EN
    logic                   rx_par_bad;
`else
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= ST_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad    <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (!rxs) begin
                        rx_state <= ST_START;
                        rx_cnt   <= '0;
                    end
                end
                ST_START: begin
                    // Half-bit check rejects short low glitches on the line
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_state <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state <= ST_PARITY;
`else
                            rx_state <= ST_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= rxs != ((^rx_shift) ^ ODD);
                        rx_state   <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // Only the first stop bit is checked; returning to IDLE here
                    // lets a following start bit be caught without a gap.
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt       <= '0;
                        rx_state     <= ST_IDLE;
                        rx_data      <= rx_shift;
                        rx_frame_err <= ~rxs;
                        rx_valid     <= 1'b1;
`ifdef UART_PARITY_EN
                        rx_parity_err <= rx_par_bad;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
